// File: rtl/param_counter.sv
// Parametrised up/down counter with modulus, parallel load, wrap-or-saturate
// behaviour, a one-cycle wrap pulse and a sticky overflow flag.
module param_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear_ovf,
   output logic [WIDTH-1:0] counter_out,
   output logic             at_limit,
   output logic             wrapped,
   output logic             ovf_sticky
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrapped_q, wrapped_d;
   logic             ovf_q, ovf_d;

   // Limit in the current direction; steps are bounded by this, never by overflow.
   always_comb begin
      at_limit = up ? (count_q == MAX_V) : (count_q == '0);
   end

   always_comb begin
      count_d   = count_q;
      wrapped_d = 1'b0;
      ovf_d     = ovf_q & ~clear_ovf;
      if (load) begin
         count_d = (load_value > MAX_V) ? MAX_V : load_value;
      end else if (enable) begin
         if (!at_limit) begin
            count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
         end else if (SATURATE) begin
            ovf_d = 1'b1;
         end else begin
            count_d   = up ? '0 : MAX_V;
            wrapped_d = 1'b1;
            ovf_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         wrapped_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
         ovf_q     <= ovf_d;
      end
   end

   assign counter_out = count_q;
   assign wrapped     = wrapped_q;
   assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: a decade wrap counter (4b, max 9) and a
// full-range 8b saturating counter, driven in lockstep against an integer model.
module tb_param_counter;

   typedef struct {
      bit reset;
      bit enable;
      bit up;
      bit load;
      int lv;
      bit clr;
   } stim_t;

   typedef struct {
      int cnt;
      bit wrap;
      bit ovf;
      bit lim;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: WIDTH=4, MAX_COUNT=9, wrap mode
   logic       a_reset = 1'b0, a_enable = 1'b0, a_up = 1'b1, a_load = 1'b0, a_clr = 1'b0;
   logic [3:0] a_lv = '0;
   logic [3:0] a_cnt;
   logic       a_lim, a_wrap, a_ovf;

   // DUT B: WIDTH=8, MAX_COUNT=255, saturate mode
   logic       b_reset = 1'b0, b_enable = 1'b0, b_up = 1'b1, b_load = 1'b0, b_clr = 1'b0;
   logic [7:0] b_lv = '0;
   logic [7:0] b_cnt;
   logic       b_lim, b_wrap, b_ovf;

   param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_dut_a (
      .clk(clk), .reset(a_reset), .enable(a_enable), .up(a_up), .load(a_load),
      .load_value(a_lv), .clear_ovf(a_clr), .counter_out(a_cnt),
      .at_limit(a_lim), .wrapped(a_wrap), .ovf_sticky(a_ovf));

   param_counter #(.WIDTH(8), .SATURATE(1'b1)) u_dut_b (
      .clk(clk), .reset(b_reset), .enable(b_enable), .up(b_up), .load(b_load),
      .load_value(b_lv), .clear_ovf(b_clr), .counter_out(b_cnt),
      .at_limit(b_lim), .wrapped(b_wrap), .ovf_sticky(b_ovf));

   exp_t qa[$];
   exp_t qb[$];
   int   ma_cnt = 0, mb_cnt = 0;
   bit   ma_ovf = 0, mb_ovf = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Reference behaviour in plain integer arithmetic on the count range 0..maxc.
   function automatic exp_t model(input stim_t s, inout int cnt, inout bit ovf,
                                  input int maxc, input bit sat);
      exp_t e;
      bit   set;
      int   nx;
      e.wrap = 1'b0;
      set    = 1'b0;
      if (s.reset) begin
         cnt = 0;
         ovf = 1'b0;
      end else begin
         if (s.load) begin
            cnt = (s.lv > maxc) ? maxc : s.lv;
         end else if (s.enable) begin
            nx = s.up ? cnt + 1 : cnt - 1;
            if (nx > maxc || nx < 0) begin
               set = 1'b1;
               if (!sat) begin
                  cnt    = s.up ? 0 : maxc;
                  e.wrap = 1'b1;
               end
            end else begin
               cnt = nx;
            end
         end
         ovf = set ? 1'b1 : (s.clr ? 1'b0 : ovf);
      end
      e.cnt = cnt;
      e.ovf = ovf;
      e.lim = s.up ? (cnt == maxc) : (cnt == 0);
      return e;
   endfunction

   function automatic stim_t mk(input bit rst, input bit en, input bit u,
                                input bit ld, input int lv, input bit clr);
      stim_t s;
      s.reset = rst; s.enable = en; s.up = u; s.load = ld; s.lv = lv; s.clr = clr;
      return s;
   endfunction

   // Apply one cycle of inputs to both DUTs and queue the expected results.
   task automatic cycle(input stim_t sa, input stim_t sb);
      @(negedge clk);
      a_reset = sa.reset; a_enable = sa.enable; a_up = sa.up; a_load = sa.load;
      a_lv = 4'(sa.lv); a_clr = sa.clr;
      b_reset = sb.reset; b_enable = sb.enable; b_up = sb.up; b_load = sb.load;
      b_lv = 8'(sb.lv); b_clr = sb.clr;
      qa.push_back(model(sa, ma_cnt, ma_ovf, 9, 1'b0));
      qb.push_back(model(sb, mb_cnt, mb_ovf, 255, 1'b1));
   endtask

   exp_t ea, eb;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (qa.size() != 0) begin
         ea = qa.pop_front();
         chk("A.counter_out", int'(a_cnt), ea.cnt);
         chk("A.wrapped", int'(a_wrap), int'(ea.wrap));
         chk("A.ovf_sticky", int'(a_ovf), int'(ea.ovf));
         chk("A.at_limit", int'(a_lim), int'(ea.lim));
      end
   end

   always @(posedge clk) begin
      #1;
      if (qb.size() != 0) begin
         eb = qb.pop_front();
         chk("B.counter_out", int'(b_cnt), eb.cnt);
         chk("B.wrapped", int'(b_wrap), int'(eb.wrap));
         chk("B.ovf_sticky", int'(b_ovf), int'(eb.ovf));
         chk("B.at_limit", int'(b_lim), int'(eb.lim));
      end
   end

   initial begin
      stim_t idle, ra, rb;
      idle = mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

      // Reset dominates load and enable
      repeat (2) cycle(mk(1, 1, 1, 1, 'h55, 0), mk(1, 1, 1, 1, 'h55, 0));

      // Decade wrap upward on A
      repeat (12) cycle(mk(0, 1, 1, 0, 0, 0), idle);

      // Down wrap from 1 on A; saturation on B
      cycle(mk(0, 0, 0, 1, 1, 0), mk(0, 0, 1, 1, 'hFE, 0));
      cycle(mk(0, 1, 0, 0, 0, 0), mk(0, 1, 1, 0, 0, 0));
      cycle(mk(0, 1, 0, 0, 0, 0), mk(0, 1, 1, 0, 0, 0));
      cycle(mk(0, 1, 0, 0, 0, 0), mk(0, 1, 1, 0, 0, 0));
      cycle(idle, mk(0, 1, 0, 0, 0, 0));

      // Load clamp with enable ignored, then load under reset
      cycle(mk(0, 1, 1, 1, 12, 0), idle);
      cycle(mk(1, 0, 1, 1, 5, 0), idle);

      // Sticky: wrap sets, clear alone clears, set beats clear
      cycle(mk(0, 0, 1, 1, 9, 0), idle);
      cycle(mk(0, 1, 1, 0, 0, 0), idle);
      cycle(mk(0, 0, 1, 0, 0, 1), idle);
      cycle(mk(0, 0, 1, 1, 9, 0), idle);
      cycle(mk(0, 1, 1, 0, 0, 1), idle);
      cycle(idle, mk(0, 0, 1, 0, 0, 1));

      // Randomised traffic on both counters
      for (int i = 0; i < 600; i++) begin
         ra = mk($urandom_range(40, 0) == 0, $urandom_range(3, 0) != 0, 1'($urandom),
                 $urandom_range(7, 0) == 0, int'($urandom_range(15, 0)),
                 $urandom_range(7, 0) == 0);
         rb = mk($urandom_range(40, 0) == 0, $urandom_range(3, 0) != 0,
                 $urandom_range(9, 0) < 5,
                 $urandom_range(9, 0) == 0,
                 ($urandom_range(1, 0) == 0) ? int'($urandom_range(255, 250))
                                             : int'($urandom_range(5, 0)),
                 $urandom_range(9, 0) == 0);
         cycle(ra, rb);
      end

      cycle(idle, idle);
      repeat (2) @(negedge clk);
      chk("A.queue_drained", qa.size(), 0);
      chk("B.queue_drained", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
